// File: rtl/fifo_wr_packer.sv
// Purpose: packs narrow WIDTH_IN beats, little-endian, into WIDTH_OUT words for the dual-clock FIFO write side.
// Latency: a word is presented the cycle after its final beat is accepted; a partial word flushes on last_in.
// Backpressure: while a word is held, ready_in follows ready_out, so one beat per cycle is sustained under ready_out=1.
module fifo_wr_packer #(
  parameter int WIDTH_IN   = 32,
  parameter int WIDTH_OUT  = 64,
  localparam int RATIO     = WIDTH_OUT / WIDTH_IN,
  localparam int CNT_WIDTH = $clog2(WIDTH_OUT / WIDTH_IN) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_IN-1:0]  data_in,
  input  logic                 valid_in,
  input  logic                 last_in,
  output logic                 ready_in,
  output logic [WIDTH_OUT-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic                 last_out,
  output logic [CNT_WIDTH-1:0] count_out
);

  // FILL accumulates beats into the word register; HOLD presents it to the FIFO.
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t               state_q, state_nxt;
  logic [WIDTH_OUT-1:0] word_q, word_nxt;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt;
  logic [CNT_WIDTH-1:0] count_q, count_nxt;
  logic                 last_q, last_nxt;
  logic                 in_xfer;

  assign in_xfer = valid_in & ready_in;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Word, beat counter and side-band registers; a reset discards any partial or pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      word_q  <= word_nxt;
      cnt_q   <= cnt_nxt;
      count_q <= count_nxt;
      last_q  <= last_nxt;
    end
  end

  // Next state and next datapath contents; a word closes on a full lane set or on last_in.
  always_comb begin
    state_nxt = state_q;
    word_nxt  = word_q;
    cnt_nxt   = cnt_q;
    count_nxt = count_q;
    last_nxt  = last_q;
    unique case (state_q)
      FILL: begin
        if (in_xfer) begin
          for (int k = 0; k < RATIO; k++) begin
            if (cnt_q == CNT_WIDTH'(k)) begin
              word_nxt[k*WIDTH_IN +: WIDTH_IN] = data_in;
            end
          end
          if ((cnt_q == CNT_WIDTH'(RATIO - 1)) || last_in) begin
            state_nxt = HOLD;
            count_nxt = cnt_q + CNT_WIDTH'(1);
            last_nxt  = last_in;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      HOLD: begin
        // The held word leaves; a beat arriving in the same cycle seeds a fresh cleared word.
        if (ready_out) begin
          state_nxt = FILL;
          word_nxt  = '0;
          cnt_nxt   = '0;
          count_nxt = '0;
          last_nxt  = 1'b0;
          if (in_xfer) begin
            word_nxt[WIDTH_IN-1:0] = data_in;
            if ((RATIO == 1) || last_in) begin
              state_nxt = HOLD;
              count_nxt = CNT_WIDTH'(1);
              last_nxt  = last_in;
            end else begin
              cnt_nxt = CNT_WIDTH'(1);
            end
          end
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Outputs: registered word and side-band, combinational ready that is forced low during reset.
  always_comb begin
    valid_out = (state_q == HOLD);
    ready_in  = !rst && ((state_q == FILL) || ready_out);
    data_out  = word_q;
    count_out = count_q;
    last_out  = last_q;
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer: three instances (RATIO 2, 1 and 4) share one stimulus stream.
// A word-level reference model predicts ready, pending word and partial word for each instance.
// Directed scenarios first, then randomized traffic with random backpressure and resets.
module tb_fifo_wr_packer;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        valid_in;
  logic        last_in;
  logic        ready_out;

  logic        a_rdy, a_vld, a_last;
  logic [63:0] a_dout;
  logic [1:0]  a_cnt;
  logic        b_rdy, b_vld, b_last;
  logic [31:0] b_dout;
  logic [0:0]  b_cnt;
  logic        c_rdy, c_vld, c_last;
  logic [63:0] c_dout;
  logic [2:0]  c_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, per instance: partial word being built and the pending output word.
  int          ratio [3] = '{2, 1, 4};
  int          win   [3] = '{32, 32, 16};
  logic [63:0] m_part[3];
  int          m_n   [3];
  logic        m_vld [3];
  logic [63:0] m_dat [3];
  int          m_cnt [3];
  logic        m_last[3];

  fifo_wr_packer #(.WIDTH_IN(32), .WIDTH_OUT(64)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .last_in(last_in),
    .ready_in(a_rdy), .data_out(a_dout), .valid_out(a_vld), .ready_out(ready_out),
    .last_out(a_last), .count_out(a_cnt)
  );

  fifo_wr_packer #(.WIDTH_IN(32), .WIDTH_OUT(32)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .last_in(last_in),
    .ready_in(b_rdy), .data_out(b_dout), .valid_out(b_vld), .ready_out(ready_out),
    .last_out(b_last), .count_out(b_cnt)
  );

  fifo_wr_packer #(.WIDTH_IN(16), .WIDTH_OUT(64)) dut_c (
    .clk(clk), .rst(rst), .data_in(data_in[15:0]), .valid_in(valid_in), .last_in(last_in),
    .ready_in(c_rdy), .data_out(c_dout), .valid_out(c_vld), .ready_out(ready_out),
    .last_out(c_last), .count_out(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every instance against the model, then advance the model by the coming clock edge.
  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      logic [63:0] od;
      logic [63:0] beat;
      logic        ov, ordy, ol, erdy;
      logic [2:0]  oc;
      case (d)
        0:       begin od = a_dout;         ov = a_vld; ordy = a_rdy; ol = a_last; oc = {1'b0, a_cnt};  end
        1:       begin od = {32'b0, b_dout}; ov = b_vld; ordy = b_rdy; ol = b_last; oc = {2'b0, b_cnt}; end
        default: begin od = c_dout;         ov = c_vld; ordy = c_rdy; ol = c_last; oc = c_cnt;          end
      endcase
      erdy = !rst && (!m_vld[d] || ready_out);
      check($sformatf("ready_in[%0d]", d), {63'b0, ordy}, {63'b0, erdy});
      check($sformatf("valid_out[%0d]", d), {63'b0, ov}, {63'b0, m_vld[d]});
      if (m_vld[d]) begin
        check($sformatf("data_out[%0d]", d), od, m_dat[d]);
        check($sformatf("count_out[%0d]", d), {61'b0, oc}, 64'(m_cnt[d]));
        check($sformatf("last_out[%0d]", d), {63'b0, ol}, {63'b0, m_last[d]});
      end else begin
        check($sformatf("partial[%0d]", d), od, m_part[d]);
      end
      if (rst) begin
        m_part[d] = '0; m_n[d] = 0; m_vld[d] = 1'b0;
      end else begin
        if (m_vld[d] && ready_out) m_vld[d] = 1'b0;
        if (valid_in && erdy) begin
          beat = (d == 2) ? {48'b0, data_in[15:0]} : {32'b0, data_in};
          m_part[d] = m_part[d] | (beat << (m_n[d] * win[d]));
          m_n[d]++;
          if (m_n[d] == ratio[d] || last_in) begin
            m_vld[d]  = 1'b1;
            m_dat[d]  = m_part[d];
            m_cnt[d]  = m_n[d];
            m_last[d] = last_in;
            m_part[d] = '0;
            m_n[d]    = 0;
          end
        end
      end
    end
  endtask

  // Drive one cycle of stimulus; returns 1 time unit after the clock edge that consumed it.
  task automatic step(input logic r, input logic v, input logic l, input logic [31:0] d, input logic ro);
    rst = r; valid_in = v; last_in = l; data_in = d; ready_out = ro;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] bt;
    int words;
    for (int d = 0; d < 3; d++) begin
      m_part[d] = '0; m_n[d] = 0; m_vld[d] = 1'b0; m_dat[d] = '0; m_cnt[d] = 0; m_last[d] = 1'b0;
    end
    rst = 1'b1; valid_in = 1'b0; last_in = 1'b0; data_in = '0; ready_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'b0, a_vld}, 64'd0);
    check("rst_data", a_dout, 64'd0);
    check("rst_count", {62'b0, a_cnt}, 64'd0);
    check("rst_last", {63'b0, a_last}, 64'd0);
    check("rst_ready", {63'b0, a_rdy}, 64'd0);

    // Two beats form one full word, visible for exactly one cycle.
    step(0, 1, 0, 32'h11111111, 1);
    step(0, 1, 0, 32'h22222222, 1);
    check("pair_data", a_dout, 64'h22222222_11111111);
    check("pair_valid", {63'b0, a_vld}, 64'd1);
    check("pair_count", {62'b0, a_cnt}, 64'd2);
    check("pair_last", {63'b0, a_last}, 64'd0);
    step(0, 0, 0, 32'h0, 1);
    check("pair_one_cycle", {63'b0, a_vld}, 64'd0);

    // Single-beat packet is flushed zero-padded.
    step(0, 1, 1, 32'hAAAA5555, 1);
    check("single_data", a_dout, 64'h00000000_AAAA5555);
    check("single_count", {62'b0, a_cnt}, 64'd1);
    check("single_last", {63'b0, a_last}, 64'd1);
    step(0, 0, 0, 32'h0, 1);

    // Backpressure freezes the word and blocks input; release with a simultaneous beat.
    step(0, 1, 0, 32'h44444444, 0);
    step(0, 1, 1, 32'h55555555, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 32'h66666666, 0);
      check("bp_ready", {63'b0, a_rdy}, 64'd0);
      check("bp_data", a_dout, 64'h55555555_44444444);
      check("bp_valid", {63'b0, a_vld}, 64'd1);
    end
    step(0, 1, 0, 32'h33333333, 1);
    check("bp_release_valid", {63'b0, a_vld}, 64'd0);
    check("bp_release_lane0", a_dout, 64'h00000000_33333333);
    step(0, 1, 1, 32'h77777777, 1);
    check("bp_next_word", a_dout, 64'h77777777_33333333);
    step(0, 0, 0, 32'h0, 1);

    // Continuous stream: ready_in never drops, RATIO=1 instance echoes each beat.
    words = 0;
    for (int i = 0; i < 8; i++) begin
      bt = $urandom;
      step(0, 1, 0, bt, 1);
      if (a_vld) words++;
      check("stream_ready", {63'b0, a_rdy}, 64'd1);
      check("r1_valid", {63'b0, b_vld}, 64'd1);
      check("r1_data", {32'b0, b_dout}, {32'b0, bt});
      check("r1_count", {63'b0, b_cnt}, 64'd1);
    end
    step(0, 0, 0, 32'h0, 1);
    if (a_vld) words++;
    check("stream_words", 64'(words), 64'd4);

    // Reset while a partial word is held discards it.
    step(0, 1, 0, 32'h00000099, 1);
    step(1, 1, 0, 32'hDEADBEEF, 1);
    check("mid_rst_valid", {63'b0, a_vld}, 64'd0);
    check("mid_rst_count", {62'b0, a_cnt}, 64'd0);
    check("mid_rst_data", a_dout, 64'd0);
    check("mid_rst_ready", {63'b0, a_rdy}, 64'd0);
    step(0, 1, 0, 32'h00000001, 1);
    step(0, 1, 0, 32'h00000002, 1);
    check("post_rst_data", a_dout, 64'h00000002_00000001);
    check("post_rst_count", {62'b0, a_cnt}, 64'd2);

    // Randomized traffic with backpressure, packet ends and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           $urandom,
           ($urandom_range(0, 9) < 7));
    end
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
